h14tx_tmds_encoder: RTL and testbench

H14TX_TMDS_ENCODER -- requirements
Module: h14tx_tmds_encoder

---
 rtl/h14tx_pkg.sv | 75 +++++++
 rtl/h14tx_tmds_chan_enc.sv | 103 ++++++++++
 rtl/h14tx_tmds_encoder.sv | 40 ++++
 tb/tb_h14tx_tmds_encoder.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/h14tx_pkg.sv
// rtl/h14tx_pkg.sv - shared types, TMDS code words and helper functions for the HDMI 1.4 TMDS encoder
package h14tx_pkg;

  // Period type carried alongside every pixel; values 5..7 fall back to CTRL.
  typedef enum logic [2:0] {
    CTRL        = 3'd0,
    VIDEO       = 3'd1,
    VIDEO_GUARD = 3'd2,
    DATA_ISLAND = 3'd3,
    DATA_GUARD  = 3'd4
  } tmds_mode_t;

  // Control-period symbols indexed by {c1,c0}; bit 0 is sent first.
  localparam logic [3:0][9:0] CTRL_CODES = {
    10'b1010101011,  // 11
    10'b0101010100,  // 10
    10'b0010101011,  // 01
    10'b1101010100   // 00
  };

  // Video leading guard band: channels 0 and 2 share one word, channel 1 uses the other.
  localparam logic [9:0] VIDEO_GUARD_CH02 = 10'b1011001100;
  localparam logic [9:0] VIDEO_GUARD_CH1  = 10'b0100110011;

  // Data-island guard band on channels 1 and 2.
  localparam logic [9:0] DATA_GUARD_WORD = 10'b0100110011;

  // TERC4 code words indexed by nibble value.
  localparam logic [15:0][9:0] TERC4_TABLE = {
    10'b1011000011,  // 1111
    10'b0101100011,  // 1110
    10'b1001110001,  // 1101
    10'b1010001110,  // 1100
    10'b1011000110,  // 1011
    10'b0110011100,  // 1010
    10'b0100111001,  // 1001
    10'b1011001100,  // 1000
    10'b0100111100,  // 0111
    10'b0110001110,  // 0110
    10'b0100011110,  // 0101
    10'b0101110001,  // 0100
    10'b1011100010,  // 0011
    10'b1011100100,  // 0010
    10'b1001100011,  // 0001
    10'b1010011100   // 0000
  };

  // Number of ones in a byte.
  function automatic logic [3:0] ones8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

  // Transition-minimised stage: XNOR chain for dense bytes, XOR chain otherwise;
  // bit 8 records which chain was used (1 = XOR).
  function automatic logic [8:0] tmds_qm(input logic [7:0] d);
    logic [8:0] q;
    logic [3:0] n1;
    logic       use_xnor;
    n1       = ones8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

endpackage

// File: rtl/h14tx_tmds_chan_enc.sv
// rtl/h14tx_tmds_chan_enc.sv - one TMDS lane: video encode with running disparity, control, TERC4 and guard words
module h14tx_tmds_chan_enc
  import h14tx_pkg::*;
#(
  parameter int unsigned ChanIdx = 0
) (
  input  logic       pixel_clk,
  input  logic       rst,
  input  tmds_mode_t mode_i,
  input  logic [7:0] video_i,
  input  logic [1:0] ctrl_i,
  input  logic [3:0] terc4_i,
  output logic [9:0] chan_o
);

  // Lane 1 carries the odd video guard word; lanes 0 and 2 the even one.
  localparam logic [9:0] GuardWord = (ChanIdx == 1) ? VIDEO_GUARD_CH1 : VIDEO_GUARD_CH02;

  logic [8:0]        qm_d;
  logic [8:0]        qm_q;
  tmds_mode_t        mode1_q;
  logic [1:0]        ctrl1_q;
  logic [3:0]        terc41_q;

  logic [9:0]        chan_d;
  logic [9:0]        chan_q;
  logic signed [4:0] cnt_d;
  logic signed [4:0] cnt_q;

  logic signed [4:0] n1_s;
  logic signed [4:0] n0_s;
  logic signed [4:0] diff_s;

  // Stage 1 combinational: transition minimisation of the incoming byte.
  always_comb begin
    qm_d = tmds_qm(video_i);
  end

  // Stage 1 register: q_m plus the side-band fields that travel with the pixel.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      qm_q     <= '0;
      mode1_q  <= CTRL;
      ctrl1_q  <= '0;
      terc41_q <= '0;
    end else begin
      qm_q     <= qm_d;
      mode1_q  <= mode_i;
      ctrl1_q  <= ctrl_i;
      terc41_q <= terc4_i;
    end
  end

  // Stage 2 combinational: pick the symbol for this period and update disparity.
  always_comb begin
    n1_s   = $signed({1'b0, ones8(qm_q[7:0])});
    n0_s   = 5'sd8 - n1_s;
    diff_s = n1_s - n0_s;
    chan_d = CTRL_CODES[ctrl1_q];
    cnt_d  = 5'sd0;
    case (mode1_q)
      VIDEO: begin
        if ((cnt_q == 5'sd0) || (n1_s == n0_s)) begin
          chan_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
          cnt_d  = qm_q[8] ? (cnt_q + diff_s) : (cnt_q - diff_s);
        end else if (((cnt_q > 5'sd0) && (n1_s > n0_s)) ||
                     ((cnt_q < 5'sd0) && (n0_s > n1_s))) begin
          chan_d = {1'b1, qm_q[8], ~qm_q[7:0]};
          cnt_d  = cnt_q + (qm_q[8] ? 5'sd2 : 5'sd0) - diff_s;
        end else begin
          chan_d = {1'b0, qm_q[8], qm_q[7:0]};
          cnt_d  = cnt_q - (qm_q[8] ? 5'sd0 : 5'sd2) + diff_s;
        end
      end
      VIDEO_GUARD: begin
        chan_d = GuardWord;
      end
      DATA_ISLAND: begin
        chan_d = TERC4_TABLE[terc41_q];
      end
      DATA_GUARD: begin
        chan_d = (ChanIdx == 0) ? TERC4_TABLE[terc41_q] : DATA_GUARD_WORD;
      end
      default: begin
        chan_d = CTRL_CODES[ctrl1_q];
      end
    endcase
  end

  // Stage 2 register: output symbol and running disparity; reset idles on control code 00.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      chan_q <= CTRL_CODES[0];
      cnt_q  <= 5'sd0;
    end else begin
      chan_q <= chan_d;
      cnt_q  <= cnt_d;
    end
  end

  assign chan_o = chan_q;

endmodule

// File: rtl/h14tx_tmds_encoder.sv
// rtl/h14tx_tmds_encoder.sv - three-lane HDMI 1.4 TMDS encoder with optional DVI-only data-island suppression
module h14tx_tmds_encoder
  import h14tx_pkg::*;
#(
  parameter bit DviOnly = 1'b0
) (
  input  logic            pixel_clk,
  input  logic            rst,
  input  tmds_mode_t      mode,
  input  logic [2:0][7:0] video,
  input  logic [2:0][1:0] ctrl,
  input  logic [2:0][3:0] terc4,
  output logic [2:0][9:0] chan
);

  tmds_mode_t mode_eff;

  // A DVI sink cannot accept data islands, so those periods are sent as control.
  always_comb begin
    mode_eff = mode;
    if (DviOnly && ((mode == DATA_ISLAND) || (mode == DATA_GUARD))) begin
      mode_eff = CTRL;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_chan
    h14tx_tmds_chan_enc #(
      .ChanIdx(i)
    ) u_enc (
      .pixel_clk(pixel_clk),
      .rst      (rst),
      .mode_i   (mode_eff),
      .video_i  (video[i]),
      .ctrl_i   (ctrl[i]),
      .terc4_i  (terc4[i]),
      .chan_o   (chan[i])
    );
  end

endmodule

// File: tb/tb_h14tx_tmds_encoder.sv
// tb/tb_h14tx_tmds_encoder.sv - directed and model-based bench for the TMDS encoder
module tb_h14tx_tmds_encoder;
  import h14tx_pkg::*;

  logic            pixel_clk;
  logic            rst;
  tmds_mode_t      mode;
  logic [2:0][7:0] video;
  logic [2:0][1:0] ctrl;
  logic [2:0][3:0] terc4;
  logic [2:0][9:0] chan;
  logic [2:0][9:0] chan_dvi;

  int total = 0;
  int bad   = 0;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] GV0 = 10'b1011001100;
  localparam logic [9:0] GV1 = 10'b0100110011;
  localparam logic [9:0] GD  = 10'b0100110011;

  h14tx_tmds_encoder #(.DviOnly(1'b0)) dut (
    .pixel_clk(pixel_clk), .rst(rst), .mode(mode), .video(video),
    .ctrl(ctrl), .terc4(terc4), .chan(chan)
  );

  h14tx_tmds_encoder #(.DviOnly(1'b1)) dut_dvi (
    .pixel_clk(pixel_clk), .rst(rst), .mode(mode), .video(video),
    .ctrl(ctrl), .terc4(terc4), .chan(chan_dvi)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  function automatic logic [9:0] ctrl_ref(input logic [1:0] c);
    case (c)
      2'b00:   return C00;
      2'b01:   return C01;
      2'b10:   return C10;
      default: return C11;
    endcase
  endfunction

  function automatic logic [9:0] terc4_ref(input logic [3:0] n);
    case (n)
      4'h0: return 10'b1010011100;
      4'h1: return 10'b1001100011;
      4'h2: return 10'b1011100100;
      4'h3: return 10'b1011100010;
      4'h4: return 10'b0101110001;
      4'h5: return 10'b0100011110;
      4'h6: return 10'b0110001110;
      4'h7: return 10'b0100111100;
      4'h8: return 10'b1011001100;
      4'h9: return 10'b0100111001;
      4'hA: return 10'b0110011100;
      4'hB: return 10'b1011000110;
      4'hC: return 10'b1010001110;
      4'hD: return 10'b1001110001;
      4'hE: return 10'b0101100011;
      default: return 10'b1011000011;
    endcase
  endfunction

  function automatic logic [9:0] video_ref(input logic [7:0] d, input int cnt_in, output int cnt_out);
    int         ones_d;
    int         n1;
    int         n0;
    int         b8;
    logic       xn;
    logic       m8;
    logic [7:0] q;
    logic [9:0] r;
    ones_d = 0;
    for (int i = 0; i < 8; i++) ones_d += int'(d[i]);
    xn = (ones_d > 4) || (ones_d == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    m8 = ~xn;
    b8 = xn ? 0 : 1;
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(q[i]);
    n0 = 8 - n1;
    if (cnt_in == 0 || n1 == n0) begin
      r       = m8 ? {2'b01, q} : {2'b10, ~q};
      cnt_out = cnt_in + (m8 ? (n1 - n0) : (n0 - n1));
    end else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1)) begin
      r       = {1'b1, m8, ~q};
      cnt_out = cnt_in + 2 * b8 + n0 - n1;
    end else begin
      r       = {1'b0, m8, q};
      cnt_out = cnt_in - 2 * (1 - b8) + n1 - n0;
    end
    return r;
  endfunction

  task automatic drive(input tmds_mode_t m, input logic [2:0][7:0] v,
                       input logic [2:0][1:0] c, input logic [2:0][3:0] t);
    mode  = m;
    video = v;
    ctrl  = c;
    terc4 = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(CTRL, '0, '0, '0);
    repeat (2) @(negedge pixel_clk);
    total++;
    if (chan !== {C00, C00, C00}) begin
      bad++; $display("FAIL reset_chan got=%b exp=%b", chan, {C00, C00, C00});
    end
    total++;
    if (chan_dvi !== {C00, C00, C00}) begin
      bad++; $display("FAIL reset_chan_dvi got=%b exp=%b", chan_dvi, {C00, C00, C00});
    end
    drive(VIDEO, {8'hA5, 8'h3C, 8'hFF}, '1, '1);
    repeat (2) @(negedge pixel_clk);
    total++;
    if (chan !== {C00, C00, C00}) begin
      bad++; $display("FAIL reset_hold got=%b exp=%b", chan, {C00, C00, C00});
    end
    total++;
    if (chan_dvi !== {C00, C00, C00}) begin
      bad++; $display("FAIL reset_hold_dvi got=%b exp=%b", chan_dvi, {C00, C00, C00});
    end
    rst = 1'b0;
    drive(CTRL, '0, '0, '0);
  endtask

  task automatic test_video_zero();
    logic [9:0] e [3];
    e = '{10'b0100000000, 10'b1111111111, 10'b0100000000};
    for (int i = 0; i < 5; i++) begin
      @(negedge pixel_clk);
      if (i >= 2) begin
        total++;
        if (chan !== {3{e[i-2]}}) begin
          bad++; $display("FAIL video_zero px=%0d got=%b exp=%b", i - 2, chan, {3{e[i-2]}});
        end
      end
      if (i < 3) drive(VIDEO, '0, '0, '0);
      else       drive(CTRL, '0, '0, '0);
    end
  endtask

  task automatic test_ctrl();
    logic [2:0][1:0] c;
    logic [2:0][9:0] e;
    for (int i = 0; i < 6; i++) begin
      @(negedge pixel_clk);
      if (i >= 2) begin
        for (int ch = 0; ch < 3; ch++) e[ch] = ctrl_ref(2'(i - 2 + ch));
        total++;
        if (chan !== e) begin
          bad++; $display("FAIL ctrl px=%0d got=%b exp=%b", i - 2, chan, e);
        end
        total++;
        if (chan_dvi !== e) begin
          bad++; $display("FAIL ctrl_dvi px=%0d got=%b exp=%b", i - 2, chan_dvi, e);
        end
      end
      if (i < 4) begin
        for (int ch = 0; ch < 3; ch++) c[ch] = 2'(i + ch);
        drive(CTRL, {8'h12, 8'h34, 8'h56}, c, 12'hABC);
      end else begin
        drive(CTRL, '0, '0, '0);
      end
    end
  endtask

  task automatic test_data_island();
    logic [2:0][3:0] tv [4];
    logic [2:0][9:0] e;
    tv = '{{4'h1, 4'h0, 4'h8}, {4'hF, 4'h0, 4'h3}, {4'h7, 4'hA, 4'hC}, {4'h2, 4'h5, 4'hE}};
    for (int i = 0; i < 6; i++) begin
      @(negedge pixel_clk);
      if (i >= 2) begin
        for (int ch = 0; ch < 3; ch++) e[ch] = terc4_ref(tv[i-2][ch]);
        total++;
        if (chan !== e) begin
          bad++; $display("FAIL data_island px=%0d got=%b exp=%b", i - 2, chan, e);
        end
        total++;
        if (chan_dvi !== {C11, C10, C01}) begin
          bad++; $display("FAIL data_island_dvi px=%0d got=%b exp=%b", i - 2, chan_dvi, {C11, C10, C01});
        end
      end
      if (i < 4) drive(DATA_ISLAND, {8'hFF, 8'h00, 8'h81}, {2'b11, 2'b10, 2'b01}, tv[i]);
      else       drive(CTRL, '0, '0, '0);
    end
  endtask

  task automatic test_data_guard();
    logic [3:0]      t0 [3];
    logic [2:0][9:0] e;
    t0 = '{4'h9, 4'h0, 4'hF};
    for (int i = 0; i < 5; i++) begin
      @(negedge pixel_clk);
      if (i >= 2) begin
        e = {GD, GD, terc4_ref(t0[i-2])};
        total++;
        if (chan !== e) begin
          bad++; $display("FAIL data_guard px=%0d got=%b exp=%b", i - 2, chan, e);
        end
        total++;
        if (chan_dvi !== {C00, C11, C10}) begin
          bad++; $display("FAIL data_guard_dvi px=%0d got=%b exp=%b", i - 2, chan_dvi, {C00, C11, C10});
        end
      end
      if (i < 3) drive(DATA_GUARD, '0, {2'b00, 2'b11, 2'b10}, {4'h6, 4'h3, t0[i]});
      else       drive(CTRL, '0, '0, '0);
    end
  endtask

  task automatic test_guard_to_video();
    tmds_mode_t      ms [7];
    logic [2:0][9:0] e  [7];
    ms = '{VIDEO, VIDEO, VIDEO, VIDEO_GUARD, VIDEO_GUARD, VIDEO, VIDEO};
    e  = '{{3{10'b0100000000}}, {3{10'b1111111111}}, {3{10'b0100000000}},
           {GV0, GV1, GV0}, {GV0, GV1, GV0},
           {3{10'b0100000000}}, {3{10'b1111111111}}};
    for (int i = 0; i < 9; i++) begin
      @(negedge pixel_clk);
      if (i >= 2) begin
        total++;
        if (chan !== e[i-2]) begin
          bad++; $display("FAIL guard_video px=%0d got=%b exp=%b", i - 2, chan, e[i-2]);
        end
        total++;
        if (chan_dvi !== e[i-2]) begin
          bad++; $display("FAIL guard_video_dvi px=%0d got=%b exp=%b", i - 2, chan_dvi, e[i-2]);
        end
      end
      if (i < 7) drive(ms[i], '0, '1, '1);
      else       drive(CTRL, '0, '0, '0);
    end
  endtask

  task automatic test_unencoded_mode();
    logic [2:0][1:0] c;
    logic [2:0][9:0] e;
    for (int i = 0; i < 5; i++) begin
      @(negedge pixel_clk);
      if (i >= 2) begin
        for (int ch = 0; ch < 3; ch++) e[ch] = ctrl_ref(2'(i - 2 + 2 * ch + 1));
        total++;
        if (chan !== e) begin
          bad++; $display("FAIL unencoded px=%0d got=%b exp=%b", i - 2, chan, e);
        end
        total++;
        if (chan_dvi !== e) begin
          bad++; $display("FAIL unencoded_dvi px=%0d got=%b exp=%b", i - 2, chan_dvi, e);
        end
      end
      if (i < 3) begin
        for (int ch = 0; ch < 3; ch++) c[ch] = 2'(i + 2 * ch + 1);
        drive(tmds_mode_t'(3'(5 + i)), {8'hC3, 8'h5A, 8'h0F}, c, 12'h5A5);
      end else begin
        drive(CTRL, '0, '0, '0);
      end
    end
  endtask

  task automatic test_video_random_reset();
    int              mc [3];
    logic [2:0][9:0] q  [$];
    logic [2:0][9:0] e;
    logic [2:0][7:0] v;
    for (int phase = 0; phase < 2; phase++) begin
      mc = '{0, 0, 0};
      q.delete();
      for (int i = 0; i < 1502; i++) begin
        @(negedge pixel_clk);
        if (i >= 2) begin
          e = q.pop_front();
          total++;
          if (chan !== e) begin
            bad++; $display("FAIL video_rand ph=%0d px=%0d got=%b exp=%b", phase, i - 2, chan, e);
          end
          total++;
          if (chan_dvi !== e) begin
            bad++; $display("FAIL video_rand_dvi ph=%0d px=%0d got=%b exp=%b", phase, i - 2, chan_dvi, e);
          end
        end
        if (i < 1500) begin
          v = 24'($urandom);
          if (i < 8) v = (i % 2 == 0) ? 24'hFFFFFF : 24'h000000;
          for (int ch = 0; ch < 3; ch++) e[ch] = video_ref(v[ch], mc[ch], mc[ch]);
          q.push_back(e);
          drive(VIDEO, v, 6'($urandom), 12'($urandom));
        end else begin
          drive(CTRL, '0, '0, '0);
        end
      end
      if (phase == 0) begin
        for (int k = 0; k < 4; k++) begin
          @(negedge pixel_clk);
          drive(VIDEO, 24'($urandom), '0, '0);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (chan !== {C00, C00, C00}) begin
          bad++; $display("FAIL async_reset got=%b exp=%b", chan, {C00, C00, C00});
        end
        total++;
        if (chan_dvi !== {C00, C00, C00}) begin
          bad++; $display("FAIL async_reset_dvi got=%b exp=%b", chan_dvi, {C00, C00, C00});
        end
        @(negedge pixel_clk);
        total++;
        if (chan !== {C00, C00, C00}) begin
          bad++; $display("FAIL async_reset_held got=%b exp=%b", chan, {C00, C00, C00});
        end
        rst = 1'b0;
        drive(CTRL, '0, '0, '0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_video_zero();
    test_ctrl();
    test_data_island();
    test_data_guard();
    test_guard_to_video();
    test_unencoded_mode();
    test_video_random_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
